shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq_pkg.sv | 25 ++
 rtl/shift_seq_step.sv | 22 ++
 rtl/shift_seq.sv | 114 +++++++++++
 tb/tb_shift_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift_seq sequential shifter.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Shift-amount width: ceil(log2(w)), at least 1.
  function automatic int shw_f(input int w);
    int r;
    r = 0;
    while ((1 << r) < w) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_seq_step.sv
// One-position shift or rotate; rot_i feeds the bit that falls off back into the vacated slot.
module shift_seq_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             lr_i,
  input  logic             rot_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (lr_i) begin
      data_o = {data_i[WIDTH-2:0], rot_i & data_i[WIDTH-1]};
    end else begin
      data_o = {rot_i & data_i[0], data_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Sequential shifter, one position per clock, with ready/done handshake.
// Defining SHIFT_SEQ_ROTATE_EN adds the rot input, which selects rotate instead of shift.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int SHW   = shw_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [SHW-1:0]   n,
  input  logic             Lr,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] out,
  output logic             ready,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             lr_q, lr_d;
  logic             rot_q, rot_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             rot_s;
  logic [WIDTH-1:0] step_s;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign rot_s = rot;
`else
  assign rot_s = 1'b0;
`endif

  shift_seq_step #(.WIDTH(WIDTH)) u_step (
    .data_i (sreg_q),
    .lr_i   (lr_q),
    .rot_i  (rot_q),
    .data_o (step_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      lr_q    <= 1'b0;
      rot_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
      rot_q   <= rot_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // ready/done are computed from the next state so they come straight off flops.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    rot_d   = rot_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sreg_d  = In;
          cnt_d   = n;
          lr_d    = Lr;
          rot_d   = rot_s;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sreg_d = step_s;
          cnt_d  = cnt_q - SHW'(1);
        end else begin
          out_d   = sreg_q;
          state_d = DONE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign out   = out_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: per-cycle schedule model plus directed literal checks.
module tb_shift_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] In = 8'h00;
  logic [2:0] n = 3'd0;
  logic       Lr = 1'b0;
  logic       rot = 1'b0;
  logic [7:0] out;
  logic       ready;
  logic       done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  shift_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (In),
    .n     (n),
    .Lr    (Lr),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rot   (rot),
`endif
    .out   (out),
    .ready (ready),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_f(input logic [7:0] x, input int k,
                                         input logic left, input logic r);
    logic [15:0] d;
    logic [7:0]  y;
    d = {x, x};
    if (r && left) begin
      d = d << k;
      y = d[15:8];
    end else if (r) begin
      d = d >> k;
      y = d[7:0];
    end else if (left) begin
      y = x << k;
    end else begin
      y = x >> k;
    end
    return y;
  endfunction

  // Model: an accepted start at edge E yields its result at edge E+n+1.
  logic [7:0] exp_out = 8'h00;
  logic [7:0] pend = 8'h00;
  logic       exp_done = 1'b0;
  logic       exp_ready = 1'b1;
  int         ec = 0;
  int         done_edge = -1;

  initial begin
    logic accept;
    forever begin
      @(posedge clk);
      ec++;
      if (rst) begin
        exp_out   = 8'h00;
        exp_done  = 1'b0;
        exp_ready = 1'b1;
        done_edge = -1;
        chk_en    = 1'b1;
      end else begin
        exp_done = (ec == done_edge);
        if (exp_done) exp_out = pend;
        accept = start && exp_ready;
        if (accept) begin
`ifdef SHIFT_SEQ_ROTATE_EN
          pend = model_f(In, int'(n), Lr, rot);
`else
          pend = model_f(In, int'(n), Lr, 1'b0);
`endif
          done_edge = ec + int'(n) + 1;
        end
        exp_ready = !accept && (ec >= done_edge);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_out", 32'(out), 32'(exp_out));
        chk("cyc_done", 32'(done), 32'(exp_done));
        chk("cyc_ready", 32'(ready), 32'(exp_ready));
        if (done === 1'b1) done_cnt++;
      end
    end
  end

  // Called at posedge+1; on return the DUT is in its done cycle (or the budget ran out).
  task automatic run_op(input string name, input logic [7:0] a, input logic [2:0] k,
                        input logic left, input logic r, input logic [7:0] exp_o);
    int lat;
    In = a; n = k; Lr = left; rot = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (lat == 0) begin
        @(posedge clk); #1;
        if (done === 1'b1) lat = i;
      end
    end
    chk({name, "_out"}, 32'(out), 32'(exp_o));
    chk({name, "_lat"}, 32'(lat), 32'(k) + 32'd1);
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("r28", 8'h80, 3'd4, 1'b0, 1'b0, 8'h08);
    @(posedge clk); #1;
    run_op("r29a", 8'h80, 3'd2, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1;
    run_op("r29b", 8'hFF, 3'd7, 1'b0, 1'b0, 8'h01);
    @(posedge clk); #1;
    run_op("lmax", 8'h01, 3'd7, 1'b1, 1'b0, 8'h80);
    @(posedge clk); #1;
    run_op("r30a", 8'hA5, 3'd0, 1'b0, 1'b0, 8'hA5);
    run_op("r30b", 8'h01, 3'd3, 1'b1, 1'b0, 8'h08);
    @(posedge clk); #1;
    run_op("mix", 8'hC3, 3'd3, 1'b1, 1'b0, 8'h18);
    @(posedge clk); #1;

    // Restart attempt in mid-shift must be ignored.
    dc = done_cnt;
    In = 8'h3C; n = 3'd5; Lr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    In = 8'hFF; n = 3'd1; Lr = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("r31_out", 32'(out), 32'h01);
    chk("r31_pulses", 32'(done_cnt - dc), 32'd1);

    // Reset two edges into an n=6 operation.
    In = 8'h40; n = 3'd6; Lr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    dc = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("r32_out", 32'(out), 32'h0);
    chk("r32_ready", 32'(ready), 32'h1);
    repeat (8) @(posedge clk);
    #1;
    chk("r32_nodone", 32'(done_cnt - dc), 32'd0);
    run_op("r32_next", 8'h40, 3'd6, 1'b0, 1'b0, 8'h01);
    @(posedge clk); #1;

`ifdef SHIFT_SEQ_ROTATE_EN
    run_op("r33a", 8'h81, 3'd1, 1'b1, 1'b1, 8'h03);
    @(posedge clk); #1;
    run_op("r33b", 8'h81, 3'd1, 1'b0, 1'b1, 8'hC0);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
